// File: rtl/vend_pkg.sv
// Vending-path shared constants: coin values and the payout FSM state encoding.
// Also imported by the coin-accept controller.
package vend_pkg;

    localparam int NICKEL_C = 5;
    localparam int DIME_C   = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_EJECT  = 3'd2,
        ST_DONE   = 3'd3,
        ST_FAULT  = 3'd4
    } disp_state_e;

endpackage

// File: rtl/change_dispenser_watchdog.sv
// Eject watchdog: counts cycles while enabled, strobes timeout in the
// ACK_TIMEOUT-th enabled cycle so the eject line is high exactly that long.
module eject_watchdog #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear dominates, otherwise advance while enabled.
    always_comb begin
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign timeout = enable && (cnt_q == CW'(ACK_TIMEOUT - 1));

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change payout controller: greedy dime/nickel ejects over a level/ack hopper
// handshake, with coin inventory tracking, short-change and sticky fault report.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W        = 5,
    parameter int CNT_W        = 6,
    parameter int INIT_NICKELS = 10,
    parameter int INIT_DIMES   = 10,
    parameter int ACK_TIMEOUT  = 15,
    parameter int LOW_MARK     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             change_valid,
    input  logic [AMT_W-1:0] change_in,
    input  logic             refill,
    input  logic [CNT_W-1:0] refill_nickels,
    input  logic [CNT_W-1:0] refill_dimes,
    input  logic             coin_ack,
    output logic             nickel_eject,
    output logic             dime_eject,
    output logic             busy,
    output logic             done,
    output logic             short_change,
    output logic             fault,
    output logic [CNT_W-1:0] nickels_left,
    output logic [CNT_W-1:0] dimes_left,
    output logic             low_stock
);

    disp_state_e      state_q, state_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] nickels_q, nickels_d;
    logic [CNT_W-1:0] dimes_q, dimes_d;
    logic             sel_dime_q, sel_dime_d;
    logic             nickel_eject_q, nickel_eject_d;
    logic             dime_eject_q, dime_eject_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             short_q, short_d;
    logic             fault_q, fault_d;
    logic             wd_timeout_s;

    eject_watchdog #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q != ST_EJECT),
        .enable  (state_q == ST_EJECT),
        .timeout (wd_timeout_s)
    );

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        nickels_d   = nickels_q;
        dimes_d     = dimes_q;
        sel_dime_d  = sel_dime_q;
        short_d     = 1'b0;
        fault_d     = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (change_valid) begin
                    remaining_d = change_in;
                    state_d     = ST_SELECT;
                end else if (refill) begin
                    nickels_d = refill_nickels;
                    dimes_d   = refill_dimes;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SELECT: begin
                if ((remaining_q >= AMT_W'(DIME_C)) && (dimes_q != '0)) begin
                    sel_dime_d = 1'b1;
                    state_d    = ST_EJECT;
                end else if ((remaining_q >= AMT_W'(NICKEL_C)) && (nickels_q != '0)) begin
                    sel_dime_d = 1'b0;
                    state_d    = ST_EJECT;
                end else begin
                    short_d = (remaining_q != '0);
                    state_d = ST_DONE;
                end
            end
            ST_EJECT: begin
                // An ack arriving in the timeout cycle still counts as delivered.
                if (coin_ack) begin
                    if (sel_dime_q) begin
                        dimes_d     = dimes_q - CNT_W'(1);
                        remaining_d = remaining_q - AMT_W'(DIME_C);
                    end else begin
                        nickels_d   = nickels_q - CNT_W'(1);
                        remaining_d = remaining_q - AMT_W'(NICKEL_C);
                    end
                    state_d = ST_SELECT;
                end else if (wd_timeout_s) begin
                    fault_d = 1'b1;
                    state_d = ST_FAULT;
                end else begin
                    state_d = ST_EJECT;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase

        dime_eject_d   = (state_d == ST_EJECT) && sel_dime_d;
        nickel_eject_d = (state_d == ST_EJECT) && !sel_dime_d;
        busy_d         = (state_d != ST_IDLE);
        done_d         = (state_d == ST_DONE);
    end

    // FSM, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            remaining_q    <= '0;
            nickels_q      <= CNT_W'(INIT_NICKELS);
            dimes_q        <= CNT_W'(INIT_DIMES);
            sel_dime_q     <= 1'b0;
            nickel_eject_q <= 1'b0;
            dime_eject_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            short_q        <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            remaining_q    <= remaining_d;
            nickels_q      <= nickels_d;
            dimes_q        <= dimes_d;
            sel_dime_q     <= sel_dime_d;
            nickel_eject_q <= nickel_eject_d;
            dime_eject_q   <= dime_eject_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            short_q        <= short_d;
            fault_q        <= fault_d;
        end
    end

    assign nickel_eject = nickel_eject_q;
    assign dime_eject   = dime_eject_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign short_change = short_q;
    assign fault        = fault_q;
    assign nickels_left = nickels_q;
    assign dimes_left   = dimes_q;
    assign low_stock    = (nickels_q <= CNT_W'(LOW_MARK)) || (dimes_q <= CNT_W'(LOW_MARK));

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus random
// payouts checked against a greedy-arithmetic reference of the inventory.
module tb_change_dispenser;

    localparam int ACK_TO = 15;
    localparam int LOWM   = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       change_valid;
    logic [4:0] change_in;
    logic       refill;
    logic [5:0] refill_nickels;
    logic [5:0] refill_dimes;
    logic       coin_ack;
    logic       nickel_eject;
    logic       dime_eject;
    logic       busy;
    logic       done;
    logic       short_change;
    logic       fault;
    logic [5:0] nickels_left;
    logic [5:0] dimes_left;
    logic       low_stock;

    int n_vec = 0;
    int n_err = 0;
    int mdl_n;
    int mdl_d;

    change_dispenser dut (
        .clk            (clk),
        .reset          (reset),
        .change_valid   (change_valid),
        .change_in      (change_in),
        .refill         (refill),
        .refill_nickels (refill_nickels),
        .refill_dimes   (refill_dimes),
        .coin_ack       (coin_ack),
        .nickel_eject   (nickel_eject),
        .dime_eject     (dime_eject),
        .busy           (busy),
        .done           (done),
        .short_change   (short_change),
        .fault          (fault),
        .nickels_left   (nickels_left),
        .dimes_left     (dimes_left),
        .low_stock      (low_stock)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_inventory(input string tag);
        check_eq({tag, "_nickels"}, 32'(nickels_left), mdl_n);
        check_eq({tag, "_dimes"}, 32'(dimes_left), mdl_d);
        check_eq({tag, "_low_stock"}, 32'(low_stock), 32'((mdl_n <= LOWM) || (mdl_d <= LOWM)));
    endtask

    task automatic do_refill(input int n, input int d);
        refill = 1'b1;
        refill_nickels = 6'(n);
        refill_dimes = 6'(d);
        @(negedge clk);
        refill = 1'b0;
        mdl_n = n;
        mdl_d = d;
        check_inventory("refill");
    endtask

    // One payout request; also_refill pulses refill with the request, noise pokes inputs while busy.
    task automatic run_request(input int amt, input int ack_dly, input bit also_refill, input bit noise);
        int nd, nn, rem;
        bit shrt;
        nd = amt / 10;
        if (nd > mdl_d) nd = mdl_d;
        rem = amt - 10 * nd;
        nn = rem / 5;
        if (nn > mdl_n) nn = mdl_n;
        rem = rem - 5 * nn;
        shrt = (rem != 0);

        change_valid = 1'b1;
        change_in = 5'(amt);
        refill = also_refill;
        refill_nickels = 6'($urandom_range(0, 63));
        refill_dimes = 6'($urandom_range(0, 63));
        @(negedge clk);
        change_valid = 1'b0;
        refill = 1'b0;
        change_in = 5'($urandom_range(0, 31));
        check_eq("busy_after_req", 32'(busy), 1);
        @(negedge clk);
        for (int c = 0; c < nd + nn; c++) begin
            check_eq("dime_eject", 32'(dime_eject), 32'(c < nd));
            check_eq("nickel_eject", 32'(nickel_eject), 32'(c >= nd));
            for (int w = 0; w < ack_dly; w++) begin
                if (noise) begin
                    change_valid = 1'b1;
                    refill = 1'b1;
                end
                @(negedge clk);
                change_valid = 1'b0;
                refill = 1'b0;
                check_eq("eject_held", 32'(dime_eject | nickel_eject), 1);
            end
            coin_ack = 1'b1;
            @(negedge clk);
            coin_ack = 1'b0;
            if (c < nd) mdl_d--;
            else mdl_n--;
            check_eq("eject_dropped", 32'(dime_eject | nickel_eject), 0);
            check_inventory("after_coin");
            @(negedge clk);
        end
        check_eq("done", 32'(done), 1);
        check_eq("short_change", 32'(short_change), 32'(shrt));
        check_eq("busy_in_done", 32'(busy), 1);
        check_eq("no_eject_in_done", 32'(dime_eject | nickel_eject), 0);
        check_inventory("at_done");
        @(negedge clk);
        check_eq("done_pulse_end", 32'(done), 0);
        check_eq("busy_end", 32'(busy), 0);
    endtask

    initial begin
        int hi;
        reset = 1'b1;
        change_valid = 1'b0;
        change_in = 5'd0;
        refill = 1'b0;
        refill_nickels = 6'd0;
        refill_dimes = 6'd0;
        coin_ack = 1'b0;
        mdl_n = 10;
        mdl_d = 10;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_fault", 32'(fault), 0);
        check_eq("rst_eject", 32'(dime_eject | nickel_eject), 0);
        check_inventory("rst");

        // Reset asserted while a dime eject is pending.
        change_valid = 1'b1;
        change_in = 5'd15;
        @(negedge clk);
        change_valid = 1'b0;
        @(negedge clk);
        check_eq("pre_reset_dime", 32'(dime_eject), 1);
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst_eject", 32'(dime_eject | nickel_eject), 0);
        check_eq("async_rst_busy", 32'(busy), 0);
        check_eq("async_rst_done", 32'(done | fault), 0);
        check_inventory("async_rst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_request(15, 2, 1'b0, 1'b0);
        do_refill(2, 0);
        run_request(20, 1, 1'b0, 1'b0);
        do_refill(10, 10);
        run_request(7, 0, 1'b0, 1'b0);
        run_request(0, 0, 1'b0, 1'b0);
        run_request(25, 3, 1'b0, 1'b1);
        run_request(30, 0, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_refill($urandom_range(0, 12), $urandom_range(0, 12));
            end else begin
                run_request($urandom_range(0, 31), $urandom_range(0, 4),
                            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        // Hopper never acks: watchdog fault is terminal.
        do_refill(10, 10);
        change_valid = 1'b1;
        change_in = 5'd15;
        @(negedge clk);
        change_valid = 1'b0;
        @(negedge clk);
        hi = 0;
        for (int i = 0; i < 40 && (dime_eject || nickel_eject); i++) begin
            hi++;
            @(negedge clk);
        end
        check_eq("eject_high_cycles", hi, ACK_TO);
        check_eq("fault_set", 32'(fault), 1);
        check_eq("fault_busy", 32'(busy), 1);
        change_valid = 1'b1;
        change_in = 5'd10;
        refill = 1'b1;
        refill_nickels = 6'd3;
        refill_dimes = 6'd3;
        coin_ack = 1'b1;
        repeat (4) @(negedge clk);
        change_valid = 1'b0;
        refill = 1'b0;
        coin_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("fault_sticky", 32'(fault), 1);
        check_eq("fault_no_eject", 32'(dime_eject | nickel_eject), 0);
        check_eq("fault_no_done", 32'(done), 0);
        check_inventory("fault");

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mdl_n = 10;
        mdl_d = 10;
        @(negedge clk);
        check_eq("post_fault_rst", 32'(fault | busy), 0);
        check_inventory("post_fault_rst");
        run_request(10, 0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
